// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencer for an unsigned shift-add multiplier that drives
// an external 2W-bit product register with independent high/low loads.
//
// Ports:
//   clk        : system clock, all state on the rising edge
//   clear_n    : asynchronous active-low reset
//   start      : multiply request, sampled only in IDLE
//   mcand      : multiplicand, latched on an accepted start
//   mplier     : multiplier, latched on an accepted start
//   abort      : synchronous cancel, honoured in every state
//   prod_q     : product register readback
//   prod_inh   : data for the product high half
//   prod_inl   : data for the product low half
//   prod_loadh : high-half load enable
//   prod_loadl : low-half load enable
//   prod_clear : registered clear pulse to the product register
//   busy       : high from the accepted start until DONE
//   done       : one-cycle pulse, product valid on prod_q
module mult_seq_ctrl #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic           clk,
    input  logic           clear_n,
    input  logic           start,
    input  logic [W-1:0]   mcand,
    input  logic [W-1:0]   mplier,
    input  logic           abort,
    input  logic [2*W-1:0] prod_q,
    output logic [W-1:0]   prod_inh,
    output logic [W-1:0]   prod_inl,
    output logic           prod_loadh,
    output logic           prod_loadl,
    output logic           prod_clear,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_CALC,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_mcand;
    logic [W-1:0]  r_mplier;
    logic          r_clear;
    logic          w_accept;
    logic          w_step;
    logic [W:0]    w_sum;

    // abort outranks a start presented in the same IDLE cycle
    assign w_accept = (r_state == S_IDLE) && start && !abort;
    assign w_step   = (r_state == S_CALC) && !abort;

    // Conditional add into the high half; the carry lands in bit W and is
    // shifted straight back into the high half, so no carry flop is needed.
    assign w_sum = prod_q[0]
                 ? {1'b0, prod_q[2*W-1:W]} + {1'b0, r_mcand}
                 : {1'b0, prod_q[2*W-1:W]};

    assign prod_clear = r_clear;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_clear  <= 1'b1;
        end else begin
            r_state <= w_next;
            // one-cycle clear pulse follows every abort edge
            r_clear <= abort;
            if (w_accept) begin
                r_mcand  <= mcand;
                r_mplier <= mplier;
                r_count  <= '0;
            end else if (w_step) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        prod_inh   = '0;
        prod_inl   = '0;
        prod_loadh = 1'b0;
        prod_loadl = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_INIT;
                end
            end
            S_INIT: begin
                busy       = 1'b1;
                prod_loadh = 1'b1;
                prod_loadl = 1'b1;
                prod_inl   = r_mplier;
                w_next     = S_CALC;
            end
            S_CALC: begin
                busy       = 1'b1;
                prod_loadh = 1'b1;
                prod_loadl = 1'b1;
                prod_inh   = w_sum[W:1];
                prod_inl   = {w_sum[0], prod_q[W-1:1]};
                if (r_count == LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // cancel: no register writes and no done in the abort cycle
        if (abort) begin
            w_next     = S_IDLE;
            prod_loadh = 1'b0;
            prod_loadl = 1'b0;
            prod_inh   = '0;
            prod_inl   = '0;
            done       = 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed and randomized checks of mult_seq_ctrl against
// plain-arithmetic products, with a behavioural product register attached.
module tb_mult_seq_ctrl;

    localparam int W  = 8;
    localparam int CW = 4;

    logic           clk;
    logic           clear_n;
    logic           start;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic           abort;
    logic [2*W-1:0] prod_q;
    logic [W-1:0]   prod_inh;
    logic [W-1:0]   prod_inl;
    logic           prod_loadh;
    logic           prod_loadl;
    logic           prod_clear;
    logic           busy;
    logic           done;

    int total;
    int bad;

    mult_seq_ctrl #(.W(W), .CW(CW)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .start      (start),
        .mcand      (mcand),
        .mplier     (mplier),
        .abort      (abort),
        .prod_q     (prod_q),
        .prod_inh   (prod_inh),
        .prod_inl   (prod_inl),
        .prod_loadh (prod_loadh),
        .prod_loadl (prod_loadl),
        .prod_clear (prod_clear),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // product register: async clear, independent half loads
    always_ff @(posedge clk or posedge prod_clear) begin
        if (prod_clear) begin
            prod_q <= '0;
        end else begin
            if (prod_loadh) prod_q[2*W-1:W] <= prod_inh;
            if (prod_loadl) prod_q[W-1:0]   <= prod_inl;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Full multiply from an IDLE cycle; busy start pulses and operand
    // changes during the operation must have no effect.
    task automatic run_mul(input logic [W-1:0] a,
                           input logic [W-1:0] b,
                           input string tag);
        logic [2*W-1:0] exp;
        int dcyc;
        logic busy_ok;
        logic load_ok;
        exp = 16'(32'(a) * 32'(b));
        dcyc = 0;
        busy_ok = 1'b1;
        load_ok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        mcand = a;
        mplier = b;
        for (int c = 1; c <= W + 2; c++) begin
            @(negedge clk);
            if (done === 1'b1 && dcyc == 0) dcyc = c;
            if (c <= W + 1 && busy !== 1'b1) busy_ok = 1'b0;
            if (c <= W + 1 && (prod_loadh !== 1'b1 || prod_loadl !== 1'b1))
                load_ok = 1'b0;
            if (c == W + 2) begin
                check({tag, "_busy_done"}, 32'(busy), 32'd0);
                check({tag, "_loads_done"}, 32'({prod_loadh, prod_loadl}), 32'd0);
                check({tag, "_prod"}, 32'(prod_q), 32'(exp));
            end
            mcand = W'($urandom);
            mplier = W'($urandom);
            start = (c <= W + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        check({tag, "_done_cycle"}, 32'(dcyc), 32'(W + 2));
        check({tag, "_busy_window"}, 32'(busy_ok), 32'd1);
        check({tag, "_load_window"}, 32'(load_ok), 32'd1);
        @(negedge clk);
        check({tag, "_after_done"}, 32'({busy, done}), 32'd0);
        check({tag, "_hold"}, 32'(prod_q), 32'(exp));
    endtask

    initial begin
        int dc[$];
        logic [2*W-1:0] dp[$];
        int seen_done;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        total = 0;
        bad = 0;
        clear_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mcand = '0;
        mplier = '0;

        repeat (3) @(negedge clk);
        check("rst_clear", 32'(prod_clear), 32'd1);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        check("rst_loads", 32'({prod_loadh, prod_loadl}), 32'd0);
        check("rst_prod", 32'(prod_q), 32'd0);
        clear_n = 1'b1;
        #1;
        check("rel_clear_held", 32'(prod_clear), 32'd1);
        @(negedge clk);
        check("rel_clear_drop", 32'(prod_clear), 32'd0);
        check("idle_loads", 32'({prod_loadh, prod_loadl}), 32'd0);

        run_mul(8'd13, 8'd11, "m13x11");
        run_mul(8'hFF, 8'hFF, "mFFxFF");
        run_mul(8'h00, 8'hA5, "m0xA5");
        run_mul(8'h80, 8'h02, "m80x02");
        run_mul(8'h01, 8'h37, "m1x37");

        // back-to-back with start held high
        @(negedge clk);
        start = 1'b1;
        mcand = 8'd3;
        mplier = 8'd5;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dc.push_back(c);
                dp.push_back(prod_q);
            end
            if (c == 1) begin
                mcand = 8'd200;
                mplier = 8'd7;
            end
            if (c == 21) start = 1'b0;
        end
        check("b2b_count", 32'(dc.size()), 32'd2);
        if (dc.size() == 2) begin
            check("b2b_gap", 32'(dc[1] - dc[0]), 32'd11);
            check("b2b_first", 32'(dp[0]), 32'h000F);
            check("b2b_second", 32'(dp[1]), 32'h0578);
        end

        // abort on the 4th CALC cycle
        @(negedge clk);
        start = 1'b1;
        mcand = 8'd9;
        mplier = 8'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        #1;
        check("abort_loads", 32'({prod_loadh, prod_loadl}), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        check("abort_clear", 32'(prod_clear), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_prod", 32'(prod_q), 32'd0);
        seen_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
            if (c == 0) check("abort_clear_1cyc", 32'(prod_clear), 32'd0);
        end
        check("abort_idle", 32'(seen_done), 32'd0);
        run_mul(8'd9, 8'd9, "m9x9");

        // abort beats start in IDLE and clears the held product
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("idle_abort_clear", 32'(prod_clear), 32'd1);
        check("idle_abort_busy", 32'(busy), 32'd0);
        check("idle_abort_prod", 32'(prod_q), 32'd0);
        @(negedge clk);
        check("idle_abort_stay", 32'(busy), 32'd0);

        // async reset mid-CALC
        @(negedge clk);
        start = 1'b1;
        mcand = 8'd200;
        mplier = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        clear_n = 1'b0;
        #1;
        check("areset_busy_done", 32'({busy, done}), 32'd0);
        check("areset_loads", 32'({prod_loadh, prod_loadl}), 32'd0);
        check("areset_clear", 32'(prod_clear), 32'd1);
        check("areset_prod", 32'(prod_q), 32'd0);
        @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
        check("areset_rel", 32'(prod_clear), 32'd0);
        run_mul(8'd6, 8'd7, "m6x7");

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_mul(ra, rb, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
